// File: rtl/cheri_cap_ld_seq.sv
// cheri_cap_ld_seq -- multicycle sequencer for CHERI capability loads (CLC).
//
// Sits behind the instruction decoder. When the decoder hands over a
// multicycle CLOAD_CAP, the sequencer:
//   - issues two 32-bit data-bus reads (addr, addr+4);
//   - collects the in-order responses;
//   - assembles the 64-bit capability and qualifies its tag;
//   - presents the result for one cycle with done_o.
//
// Optional feature (compile-time macro CHERI_CAP_LD_ALIGN_CHECK_EN):
//   When defined, a start whose address is not 8-byte aligned issues no bus
//   traffic. It completes on the next cycle with err_o=1, a zero tag and
//   zero data. When undefined, misaligned addresses are passed to the bus
//   unchanged.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                decoded CLOAD_CAP & multicycle & instruction valid
//   addr_i                 effective capability address (sampled on start)
//   lc_perm_i              load-capability permission (sampled on start)
//   kill_i                 pipeline flush, abandons the current operation
//   data_req_o/addr_o      data-bus request and address
//   data_gnt_i             request accepted
//   data_rvalid_i          response valid
//   data_rdata_i           response data
//   data_rtag_i            response tag
//   data_err_i             response bus error
//   busy_o                 sequencer not idle
//   done_o                 one-cycle result pulse
//   cap_lo_o/cap_hi_o      capability words (valid with done_o)
//   cap_tag_o              qualified tag (valid with done_o)
//   err_o                  bus error / misalignment (valid with done_o)

module cheri_cap_ld_seq #(
    parameter int DataAddrW      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [DataAddrW-1:0] addr_i,
    input  logic                 lc_perm_i,
    input  logic                 kill_i,
    output logic                 data_req_o,
    output logic [DataAddrW-1:0] data_addr_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic [31:0]          data_rdata_i,
    input  logic                 data_rtag_i,
    input  logic                 data_err_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [31:0]          cap_lo_o,
    output logic [31:0]          cap_hi_o,
    output logic                 cap_tag_o,
    output logic                 err_o
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ_LO   = 3'd1,
        REQ_HI   = 3'd2,
        WAIT_RSP = 3'd3,
        DRAIN    = 3'd4,
        DONE     = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [DataAddrW-1:0] addr_q;
    logic                 lc_perm_q;
    logic [1:0]           out_q, out_d;
    logic [1:0]           rsp_q, rsp_d;
    logic [31:0]          lo_q, hi_q;
    logic                 tag0_q, tag1_q, err_q;

    // Result registers that keep the last delivered result after DONE.
    logic [31:0]          hold_lo_q, hold_hi_q;
    logic                 hold_tag_q, hold_err_q;

    logic        at_limit;
    logic        gnt_fire;
    logic        rsp_fire;
    logic        err_now;
    logic        accept;
    logic        misalign;
    logic [31:0] res_lo, res_hi;
    logic        res_tag;

    `ifdef CHERI_CAP_LD_ALIGN_CHECK_EN
    assign misalign = (addr_i[2:0] != 3'b000);
    `else
    assign misalign = 1'b0;
    `endif

    assign at_limit = (out_q == 2'(MaxOutstanding));
    assign gnt_fire = data_req_o & data_gnt_i;
    // A response with nothing outstanding is spurious and dropped.
    assign rsp_fire = data_rvalid_i & (out_q != 2'd0);
    assign err_now  = err_q | (rsp_fire & data_err_i);
    assign accept   = (state_q == IDLE) & start_i & ~kill_i;
    assign out_d    = out_q + {1'b0, gnt_fire} - {1'b0, rsp_fire};
    assign rsp_d    = rsp_q + {1'b0, rsp_fire};

    // Request generation. Once an error is seen, the high word is not
    // requested; its slot is simply skipped.
    always_comb begin
        data_req_o  = 1'b0;
        data_addr_o = '0;
        case (state_q)
            REQ_LO: begin
                data_req_o  = ~at_limit;
                data_addr_o = addr_q;
            end
            REQ_HI: begin
                data_req_o  = ~at_limit & ~err_q;
                data_addr_o = addr_q + DataAddrW'(4);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = misalign ? DONE : REQ_LO;
            end
            REQ_LO: begin
                if (kill_i)        state_d = DRAIN;
                else if (gnt_fire) state_d = REQ_HI;
            end
            REQ_HI: begin
                if (kill_i)        state_d = DRAIN;
                else if (err_now)  state_d = (out_d == 2'd0) ? DONE : WAIT_RSP;
                else if (gnt_fire) state_d = WAIT_RSP;
            end
            WAIT_RSP: begin
                if (kill_i)
                    state_d = DRAIN;
                else if ((rsp_d == 2'd2) || (err_now && (out_d == 2'd0)))
                    state_d = DONE;
            end
            DRAIN: begin
                if (out_d == 2'd0) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            out_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Operation context and response capture. Responses absorbed in DRAIN
    // belong to an abandoned operation and are not recorded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            lc_perm_q <= 1'b0;
            rsp_q     <= 2'd0;
            lo_q      <= 32'd0;
            hi_q      <= 32'd0;
            tag0_q    <= 1'b0;
            tag1_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (accept) begin
            addr_q    <= addr_i;
            lc_perm_q <= lc_perm_i;
            rsp_q     <= 2'd0;
            lo_q      <= 32'd0;
            hi_q      <= 32'd0;
            tag0_q    <= 1'b0;
            tag1_q    <= 1'b0;
            err_q     <= misalign;
        end else if (rsp_fire && (state_q != DRAIN)) begin
            rsp_q <= rsp_d;
            if (rsp_q == 2'd0) begin
                lo_q   <= data_rdata_i;
                tag0_q <= data_rtag_i;
            end else begin
                hi_q   <= data_rdata_i;
                tag1_q <= data_rtag_i;
            end
            if (data_err_i) err_q <= 1'b1;
        end
    end

    // An errored load never exposes data or a valid tag.
    assign res_lo  = err_q ? 32'd0 : lo_q;
    assign res_hi  = err_q ? 32'd0 : hi_q;
    assign res_tag = tag0_q & tag1_q & lc_perm_q & ~err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_lo_q  <= 32'd0;
            hold_hi_q  <= 32'd0;
            hold_tag_q <= 1'b0;
            hold_err_q <= 1'b0;
        end else if (state_q == DONE) begin
            hold_lo_q  <= res_lo;
            hold_hi_q  <= res_hi;
            hold_tag_q <= res_tag;
            hold_err_q <= err_q;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign cap_lo_o  = done_o ? res_lo  : hold_lo_q;
    assign cap_hi_o  = done_o ? res_hi  : hold_hi_q;
    assign cap_tag_o = done_o ? res_tag : hold_tag_q;
    assign err_o     = done_o ? err_q   : hold_err_q;

endmodule

// File: tb/tb_cheri_cap_ld_seq.sv
// Directed testbench for cheri_cap_ld_seq.

module tb_cheri_cap_ld_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] addr_i;
    logic        lc_perm_i;
    logic        kill_i;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_rtag_i;
    logic        data_err_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] cap_lo_o;
    logic [31:0] cap_hi_o;
    logic        cap_tag_o;
    logic        err_o;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    cheri_cap_ld_seq #(.DataAddrW(32), .MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .addr_i(addr_i),
        .lc_perm_i(lc_perm_i), .kill_i(kill_i), .data_req_o(data_req_o),
        .data_addr_o(data_addr_o), .data_gnt_i(data_gnt_i),
        .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
        .data_rtag_i(data_rtag_i), .data_err_i(data_err_i), .busy_o(busy_o),
        .done_o(done_o), .cap_lo_o(cap_lo_o), .cap_hi_o(cap_hi_o),
        .cap_tag_o(cap_tag_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_bus();
        start_i = 0; kill_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
        data_rdata_i = 0; data_rtag_i = 0; data_err_i = 0;
    endtask

    // One full load with immediate grants after `stall` refused cycles and
    // rvalid one cycle after each grant.
    task automatic run_load(input string nm, input logic [31:0] a, input logic perm,
                            input logic [31:0] d0, input logic t0,
                            input logic [31:0] d1, input logic t1,
                            input int stall, input logic exp_tag);
        int t_start;
        idle_bus();
        start_i = 1; addr_i = a; lc_perm_i = perm;
        #1;
        chk({nm, ".idle_busy"}, 32'(busy_o), 0);
        t_start = cyc;
        tick();
        idle_bus();
        start_i = 1;                // start while busy is ignored
        for (int i = 0; i < stall; i++) begin
            #1;
            chk({nm, ".stall_req"}, 32'(data_req_o), 1);
            chk({nm, ".stall_addr"}, data_addr_o, a);
            tick();
        end
        start_i = 0;
        data_gnt_i = 1;
        #1;
        chk({nm, ".lo_req"}, 32'(data_req_o), 1);
        chk({nm, ".lo_addr"}, data_addr_o, a);
        tick();
        data_gnt_i = 1; data_rvalid_i = 1; data_rdata_i = d0; data_rtag_i = t0;
        #1;
        chk({nm, ".hi_req"}, 32'(data_req_o), 1);
        chk({nm, ".hi_addr"}, data_addr_o, a + 32'd4);
        tick();
        data_gnt_i = 0; data_rvalid_i = 1; data_rdata_i = d1; data_rtag_i = t1;
        #1;
        chk({nm, ".wait_req"}, 32'(data_req_o), 0);
        chk({nm, ".wait_done"}, 32'(done_o), 0);
        tick();
        idle_bus();
        #1;
        chk({nm, ".done"}, 32'(done_o), 1);
        chk({nm, ".latency"}, 32'(cyc - t_start), 32'(4 + stall));
        chk({nm, ".cap_lo"}, cap_lo_o, d0);
        chk({nm, ".cap_hi"}, cap_hi_o, d1);
        chk({nm, ".tag"}, 32'(cap_tag_o), 32'(exp_tag));
        chk({nm, ".err"}, 32'(err_o), 0);
        tick();
        #1;
        chk({nm, ".done_drop"}, 32'(done_o), 0);
        chk({nm, ".busy_drop"}, 32'(busy_o), 0);
        chk({nm, ".lo_hold"}, cap_lo_o, d0);
    endtask

    initial begin
        rst_ni = 0; addr_i = 0; lc_perm_i = 0;
        idle_bus();
        #2;
        chk("rst.busy", 32'(busy_o), 0);
        chk("rst.done", 32'(done_o), 0);
        chk("rst.req", 32'(data_req_o), 0);
        chk("rst.addr", data_addr_o, 0);
        chk("rst.lo", cap_lo_o, 0);
        chk("rst.hi", cap_hi_o, 0);
        chk("rst.tag", 32'(cap_tag_o), 0);
        chk("rst.err", 32'(err_o), 0);
        tick(); tick();
        rst_ni = 1;
        tick();

        // start together with kill is ignored
        start_i = 1; kill_i = 1; addr_i = 32'h2000_0010; lc_perm_i = 1;
        tick();
        idle_bus();
        #1;
        chk("startkill.busy", 32'(busy_o), 0);
        tick();

        run_load("basic", 32'h2000_0010, 1, 32'hAAAA_0001, 1, 32'h5555_0002, 1, 0, 1);
        run_load("noperm", 32'h2000_0010, 0, 32'hAAAA_0001, 1, 32'h5555_0002, 1, 0, 0);
        run_load("tag1z", 32'h2000_0010, 1, 32'hAAAA_0001, 1, 32'h5555_0002, 0, 0, 0);
        run_load("stall", 32'h2000_0010, 1, 32'h1234_5678, 1, 32'h9ABC_DEF0, 1, 3, 1);

        // Bus error on word0: the already-granted high word is drained,
        // nothing new is requested, and the result is squashed.
        tick();
        start_i = 1; addr_i = 32'h3000_0000; lc_perm_i = 1;
        tick();
        idle_bus(); data_gnt_i = 1;
        tick();
        data_gnt_i = 1; data_rvalid_i = 1; data_rdata_i = 32'hDEAD_BEEF;
        data_rtag_i = 1; data_err_i = 1;
        tick();
        idle_bus(); data_rvalid_i = 1; data_rdata_i = 32'hCAFE_F00D; data_rtag_i = 1;
        #1;
        chk("buserr.no_req", 32'(data_req_o), 0);
        chk("buserr.not_done", 32'(done_o), 0);
        tick();
        idle_bus();
        #1;
        chk("buserr.done", 32'(done_o), 1);
        chk("buserr.err", 32'(err_o), 1);
        chk("buserr.tag", 32'(cap_tag_o), 0);
        chk("buserr.lo", cap_lo_o, 0);
        chk("buserr.hi", cap_hi_o, 0);
        tick();

        // Kill in WAIT_RSP with one response still outstanding.
        start_i = 1; addr_i = 32'h4000_0000; lc_perm_i = 1;
        tick();
        idle_bus(); data_gnt_i = 1;
        tick();
        data_gnt_i = 1; data_rvalid_i = 1; data_rdata_i = 32'h1111_1111; data_rtag_i = 1;
        tick();
        idle_bus(); kill_i = 1;
        #1;
        chk("kill.busy_wait", 32'(busy_o), 1);
        tick();
        idle_bus(); data_rvalid_i = 1; data_rdata_i = 32'h2222_2222; data_rtag_i = 1;
        #1;
        chk("kill.drain_req", 32'(data_req_o), 0);
        chk("kill.drain_busy", 32'(busy_o), 1);
        chk("kill.drain_done", 32'(done_o), 0);
        tick();
        idle_bus();
        #1;
        chk("kill.idle_busy", 32'(busy_o), 0);
        chk("kill.idle_done", 32'(done_o), 0);
        tick();
        run_load("afterkill", 32'h4000_0008, 1, 32'h0BAD_CAFE, 1, 32'hFACE_0001, 1, 0, 1);

`ifdef CHERI_CAP_LD_ALIGN_CHECK_EN
        start_i = 1; addr_i = 32'h2000_0014; lc_perm_i = 1;
        tick();
        idle_bus();
        #1;
        chk("align.no_req", 32'(data_req_o), 0);
        chk("align.done", 32'(done_o), 1);
        chk("align.err", 32'(err_o), 1);
        chk("align.tag", 32'(cap_tag_o), 0);
        chk("align.lo", cap_lo_o, 0);
        chk("align.hi", cap_hi_o, 0);
        tick();
        #1;
        chk("align.busy", 32'(busy_o), 0);
`else
        run_load("misaligned", 32'h2000_0014, 1, 32'h7777_0001, 1, 32'h8888_0002, 1, 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cheri_cap_ld_seq.md
Name: cheri_cap_ld_seq

Overview:
- Multicycle sequencer for capability loads (CLC).
- Sits directly downstream of the CHERI instruction decoder. Triggered when the decoder flags CLOAD_CAP as a multicycle operation (tsafe mode without pipelined load-barrier).
- Issues two 32-bit data-bus transactions (low word, high word) and collects in-order responses.
- Assembles a 64-bit capability plus tag, applies tag qualification, and hands one result to writeback with a single-cycle done pulse.

Parameters:
- DataAddrW, 32, width of the data-bus address.
- MaxOutstanding, 2, maximum granted-but-unanswered requests (legal values 1 or 2).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  decoded CLOAD_CAP & multicycle & instruction valid.
- addr_i  input  DataAddrW  effective capability address, sampled on accepted start.
- lc_perm_i  input  1  authorising capability holds load-capability permission, sampled with start.
- kill_i  input  1  pipeline flush; abandons the current operation.
- data_req_o  output  1  data-bus request.
- data_addr_o  output  DataAddrW  request address.
- data_gnt_i  input  1  request accepted.
- data_rvalid_i  input  1  response valid.
- data_rdata_i  input  32  response data.
- data_rtag_i  input  1  memory tag bit accompanying the response.
- data_err_i  input  1  bus error, qualified by rvalid.
- busy_o  output  1  sequencer not idle; decoder stalls issue.
- done_o  output  1  one-cycle result pulse.
- cap_lo_o  output  32  word at addr.
- cap_hi_o  output  32  word at addr+4.
- cap_tag_o  output  1  qualified tag.
- err_o  output  1  bus error or misalignment, valid with done_o.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; response counter and outstanding counter 0; captured words, tags and error cleared.
- FSM states: IDLE, REQ_LO, REQ_HI, WAIT_RSP, DRAIN, DONE.
- IDLE:
  - start_i=1 and kill_i=0: latch addr_i and lc_perm_i, go to REQ_LO.
  - start_i together with kill_i: ignored.
- REQ_LO: data_req_o=1, data_addr_o=addr. On data_gnt_i go to REQ_HI.
- REQ_HI: data_req_o=1, data_addr_o=addr+4, wrapping modulo 2^DataAddrW. On data_gnt_i go to WAIT_RSP.
- Request hold: req and addr stay stable until grant. No request is issued while outstanding == MaxOutstanding.
- Responses: arrive in order. The first rvalid fills cap_lo with tag0; the second fills cap_hi with tag1.
  - rvalid may arrive in the same cycle as a grant, including word0 rvalid during REQ_HI.
- Error: any data_err_i sets a sticky err. No further requests are issued. The sequencer waits for all outstanding responses, then goes to DONE.
- WAIT_RSP → DONE when 2 responses have been received, or when errored and outstanding == 0.
- DONE (one cycle):
  - done_o=1.
  - cap_tag_o = tag0 & tag1 & lc_perm & ~err.
  - err_o = err. If err, cap_lo_o/cap_hi_o are forced to 0.
  - Next state IDLE. cap/tag/err outputs hold their last values afterwards; they are valid only with done_o.
- Kill: kill_i in any non-IDLE state except DONE goes to DRAIN.
  - DRAIN: data_req_o=0; absorb the remaining granted responses; when outstanding==0 go to IDLE with no done_o.
  - kill_i during DONE has no effect; the pulse still fires.
- busy_o = state != IDLE. start_i while busy is ignored.
- Minimum latency, with immediate grants and rvalid one cycle after each grant:
  - start at cycle 0 → req_lo cycle 1 → req_hi cycle 2 (word0 rvalid) → word1 rvalid cycle 3 → done_o cycle 4.
- Outstanding counter: +1 on grant, −1 on rvalid, both in the same cycle nets 0. It never underflows; an rvalid with outstanding==0 is ignored.

Optional Feature:
- Macro: CHERI_CAP_LD_ALIGN_CHECK_EN.
- Defined: on start, if addr_i[2:0] != 0, no bus request is issued; go straight to DONE with err_o=1, cap_tag_o=0 and zero data (latency 1 cycle).
- Undefined: no alignment check; misaligned addresses are issued as-is and the bus handles them.

Test Plan:
- Basic load: start addr=0x2000_0010, lc_perm=1, immediate grants; rdata 0xAAAA_0001 / 0x5555_0002, both rtag=1 → done_o at cycle 4, cap_lo=0xAAAA_0001, cap_hi=0x5555_0002, tag=1, err=0.
- Tag qualification: same load with lc_perm=0 → tag=0. Same load with lc_perm=1 but word1 rtag=0 → tag=0. Data is intact in both cases.
- Grant stall: data_gnt_i low 3 cycles in REQ_LO → data_req_o and data_addr_o=0x2000_0010 held stable; done_o delayed by 3 cycles.
- Bus error: data_err_i on word0 → no further requests after the pending one; done_o with err_o=1, tag=0, cap=0.
- Kill mid-op: kill_i in WAIT_RSP with 1 outstanding → DRAIN; busy_o drops the cycle after the final rvalid; no done_o; the next start completes normally.
- Align check, macro defined: start addr=0x2000_0014 → no data_req_o; done_o the next cycle with err_o=1. With the macro undefined, the same start issues normally.
